// File: rtl/mul_pipe.sv
// Pipelined N x N multiplier with RV32M/RV64M high/low modes, valid/ready handshake and flush.
// Partial products are accumulated in carry-save form across the slots; the final add sits in the last slot.
module mul_pipe #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned W    = 2 * N + 2;
    localparam int unsigned ROWS = N + 1;
    localparam int unsigned RPS  = (ROWS + STAGES - 1) / STAGES;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULH   = 2'b01;
    localparam logic [1:0] MODE_MULHSU = 2'b10;

    // Fold partial-product rows [lo, hi) into a (sum, carry) pair with 3:2 compressors.
    // The multiplier's top row has negative weight: it is added inverted, its +1 was injected up front.
    function automatic logic [2*W-1:0] csa_rows(
        input logic [W-1:0]  sum_i,
        input logic [W-1:0]  cry_i,
        input logic [N:0]    a_e,
        input logic [N:0]    b_e,
        input int unsigned   lo,
        input int unsigned   hi
    );
        logic [W-1:0] s, c, p, cn, aw;
        logic [N:0]   bb;
        s  = sum_i;
        c  = cry_i;
        bb = b_e;
        aw = {{(W - N - 1){a_e[N]}}, a_e};
        for (int unsigned j = 0; j < ROWS; j++) begin
            if (j >= lo && j < hi) begin
                p = aw << j;
                if (j == N) p = ~p;
                p  = bb[0] ? p : '0;
                cn = ((s & c) | (s & p) | (c & p)) << 1;
                s  = s ^ c ^ p;
                c  = cn;
            end
            bb = bb >> 1;
        end
        return {s, c};
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_src;
    logic [STAGES-1:0] space;
    logic [W-1:0]      sum_q   [STAGES];
    logic [W-1:0]      cry_q   [STAGES];
    logic [W-1:0]      sum_src [STAGES];
    logic [W-1:0]      cry_src [STAGES];
    logic [W-1:0]      sum_d   [STAGES];
    logic [W-1:0]      cry_d   [STAGES];
    logic [N:0]        a_q     [STAGES];
    logic [N:0]        b_q     [STAGES];
    logic [N:0]        a_src   [STAGES];
    logic [N:0]        b_src   [STAGES];
    logic [1:0]        mode_q  [STAGES];
    logic [1:0]        mode_src[STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [TAG_W-1:0]  tag_src [STAGES];
    logic [N-1:0]      res_q;
    logic [N-1:0]      res_d;
    logic [2*N-1:0]    prod;
    logic [N:0]        a_ext;
    logic [N:0]        b_ext;
    logic              sign_a;
    logic              sign_b;
    logic              in_fire;
    logic              space_acc;

    // Operand extension to N+1 bits according to the signedness of the mode.
    always_comb begin
        sign_a = (in_mode == MODE_MULH) || (in_mode == MODE_MULHSU);
        sign_b = (in_mode == MODE_MULH);
        a_ext  = {sign_a & in_a[N-1], in_a};
        b_ext  = {sign_b & in_b[N-1], in_b};
    end

    // A slot can take new contents when it or any slot downstream of it is empty, or the output drains.
    always_comb begin
        space_acc = out_ready;
        space     = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            space_acc = space_acc | ~vld_q[k];
            space[k]  = space_acc;
        end
        in_ready = rst_n & ~flush & space[0];
        in_fire  = in_valid & in_ready;
    end

    // Per-slot datapath: source selection, row reduction, final add in the last slot.
    always_comb begin
        vld_src[0]  = in_fire;
        sum_src[0]  = '0;
        cry_src[0]  = W'(b_ext[N]);
        a_src[0]    = a_ext;
        b_src[0]    = b_ext;
        mode_src[0] = in_mode;
        tag_src[0]  = in_tag;
        for (int unsigned k = 1; k < STAGES; k++) begin
            vld_src[k]  = vld_q[k-1];
            sum_src[k]  = sum_q[k-1];
            cry_src[k]  = cry_q[k-1];
            a_src[k]    = a_q[k-1];
            b_src[k]    = b_q[k-1];
            mode_src[k] = mode_q[k-1];
            tag_src[k]  = tag_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            {sum_d[k], cry_d[k]} = csa_rows(sum_src[k], cry_src[k], a_src[k], b_src[k],
                                            RPS * k, RPS * (k + 1));
        end
        prod  = (2 * N)'(sum_d[STAGES-1] + cry_d[STAGES-1]);
        res_d = (mode_src[STAGES-1] == MODE_MUL) ? prod[N-1:0] : prod[2*N-1:N];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            res_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k]  <= '0;
                cry_q[k]  <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                mode_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (flush) begin
                    vld_q[k] <= 1'b0;
                end else if (space[k]) begin
                    vld_q[k] <= vld_src[k];
                end
                if (space[k] && vld_src[k]) begin
                    sum_q[k]  <= sum_d[k];
                    cry_q[k]  <= cry_d[k];
                    a_q[k]    <= a_src[k];
                    b_q[k]    <= b_src[k];
                    mode_q[k] <= mode_src[k];
                    tag_q[k]  <= tag_src[k];
                end
            end
            if (space[STAGES-1] && vld_src[STAGES-1]) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_result = res_q;
    assign out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: directed checks on a 3-stage instance, scoreboards on 1/2/3/4-stage instances
// sharing one stimulus stream.
module tb_mul_pipe;

    localparam int unsigned NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;

    logic        rdy  [NI];
    logic        ovld [NI];
    logic [31:0] ores [NI];
    logic [4:0]  otag [NI];
    int          pend [NI];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model built on native 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (m)
            2'b00:   begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            2'b01:   begin p = sa * sb; return p[63:32]; end
            2'b10:   begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            default: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned STG = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 2 : 4;
        logic [36:0] sb_q [$];
        logic [36:0] e;

        mul_pipe #(.N(32), .STAGES(STG), .TAG_W(5)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .in_valid   (in_valid),
            .in_ready   (rdy[g]),
            .in_mode    (in_mode),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_tag     (in_tag),
            .out_valid  (ovld[g]),
            .out_ready  (out_ready),
            .out_result (ores[g]),
            .out_tag    (otag[g])
        );

        // Transfers are predicted on the falling edge for the rising edge that follows.
        always @(negedge clk) begin
            if (!rst_n || flush) begin
                sb_q.delete();
            end else begin
                if (ovld[g] && out_ready) begin
                    chk($sformatf("s%0d_sb_nonempty", STG), 64'(sb_q.size() != 0), 64'(1));
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk($sformatf("s%0d_res", STG), 64'(ores[g]), 64'(e[31:0]));
                        chk($sformatf("s%0d_tag", STG), 64'(otag[g]), 64'(e[36:32]));
                    end
                end
                if (in_valid && rdy[g]) begin
                    sb_q.push_back({in_tag, ref_mul(in_mode, in_a, in_b)});
                end
            end
            pend[g] = sb_q.size();
        end
    end

    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output int unsigned acc);
        bit ok;
        ok       = 1'b0;
        acc      = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ok = rdy[0];
            @(posedge clk); #1;
            if (ok) begin
                acc = cyc;
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'(rdy[0]), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ovld[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_out_timeout", 64'(ovld[0]), 64'(1));
    endtask

    task automatic run_one(input string name, input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int unsigned acc;
        int unsigned fire;
        bit          ok;
        send(m, a, b, 5'd1, acc);
        wait_out(ok);
        fire = cyc + 1;
        chk({name, "_res"}, 64'(ores[0]), 64'(exp));
        chk({name, "_lat"}, 64'(fire - acc), 64'(3));
        @(posedge clk); #1;
    endtask

    initial begin
        int unsigned acc;
        int unsigned fire;
        logic [31:0] exp20;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        acc       = 0;
        fire      = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 64'(ovld[0]), 64'(0));
        chk("rst_res", 64'(ores[0]), 64'(0));
        chk("rst_tag", 64'(otag[0]), 64'(0));
        chk("rst_rdy", 64'(rdy[0]), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 64'(rdy[0]), 64'(1));

        // Mode and sign corners.
        run_one("mulh_8000",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_one("mul_8000",    2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run_one("mulhu_8000",  2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_one("mulhsu_8000", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);
        run_one("mulhsu_ffff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_one("mulhu_ffff",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_one("mulh_ffff",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_one("mul_ffff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        // Back-to-back stream of ten tagged operations.
        out_ready = 1'b1;
        fork
            begin : drv
                for (int i = 0; i < 10; i++) begin
                    in_valid = 1'b1;
                    in_mode  = 2'($urandom_range(3));
                    in_a     = $urandom;
                    in_b     = $urandom;
                    in_tag   = 5'(i);
                    @(negedge clk);
                    chk("stream_rdy", 64'(rdy[0]), 64'(1));
                    if (i == 0) acc = cyc + 1;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin : mon
                bit got;
                wait_out(got);
                fire = cyc + 1;
                for (int j = 0; j < 10; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("stream_vld", 64'(ovld[0]), 64'(1));
                    chk("stream_tag", 64'(otag[0]), 64'(j));
                end
            end
        join
        chk("stream_lat", 64'(fire - acc), 64'(3));
        @(posedge clk); #1;

        // Backpressure: fill three slots, hold the output for five cycles, then drain.
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'b11;
            in_a     = 32'h1234_5678 + 32'(i);
            in_b     = 32'h9ABC_DEF0 - 32'(i);
            in_tag   = 5'(20 + i);
            @(negedge clk);
            chk("bp_rdy", 64'(rdy[0]), 64'(1));
            @(posedge clk); #1;
        end
        exp20   = ref_mul(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
        in_mode = 2'b01;
        in_a    = 32'hDEAD_BEEF;
        in_b    = 32'h0BAD_F00D;
        in_tag  = 5'd23;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_full_rdy", 64'(rdy[0]), 64'(0));
            chk("bp_hold_vld", 64'(ovld[0]), 64'(1));
            chk("bp_hold_tag", 64'(otag[0]), 64'(20));
            chk("bp_hold_res", 64'(ores[0]), 64'(exp20));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("bp_drain_vld", 64'(ovld[0]), 64'(1));
            chk("bp_drain_tag", 64'(otag[0]), 64'(20 + j));
            @(posedge clk); #1;
            if (j == 0) in_valid = 1'b0;
        end

        // Flush with three operations in flight and a fourth offered.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'b00;
            in_a     = 32'(100 + i);
            in_b     = 32'(7);
            in_tag   = 5'(10 + i);
            @(negedge clk);
            chk("fl_fill_rdy", 64'(rdy[0]), 64'(1));
            @(posedge clk); #1;
        end
        flush  = 1'b1;
        in_tag = 5'd13;
        @(negedge clk);
        chk("fl_rdy", 64'(rdy[0]), 64'(0));
        chk("fl_pre_vld", 64'(ovld[0]), 64'(1));
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            chk("fl_post_vld", 64'(ovld[0]), 64'(0));
        end
        @(posedge clk); #1;
        run_one("post_flush", 2'b00, 32'd3, 32'd5, 32'd15);

        // Reset with a full pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'b00;
            in_a     = 32'hABCD_0001 + 32'(i);
            in_b     = 32'h0000_0003;
            in_tag   = 5'(24 + i);
            @(negedge clk);
            chk("mr_fill_rdy", 64'(rdy[0]), 64'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("mr_rdy", 64'(rdy[0]), 64'(0));
        @(posedge clk); #1;
        chk("mr_vld", 64'(ovld[0]), 64'(0));
        chk("mr_res", 64'(ores[0]), 64'(0));
        chk("mr_tag", 64'(otag[0]), 64'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mr_rel_rdy", 64'(rdy[0]), 64'(1));

        // Randomized traffic with backpressure and occasional flushes.
        for (int c = 0; c < 13000; c++) begin
            in_valid  = ($urandom_range(9) != 0);
            in_mode   = 2'($urandom_range(3));
            in_a      = pick_operand();
            in_b      = pick_operand();
            in_tag    = 5'($urandom);
            out_ready = ($urandom_range(7) != 0);
            flush     = ($urandom_range(499) == 0);
            @(posedge clk); #1;
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("drain_pend%0d", g), 64'(pend[g]), 64'(0));
            chk($sformatf("drain_vld%0d", g), 64'(ovld[g]), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
